// File: rtl/fetch_pc_unit.sv
// Fetch program-counter sequencer: owns the fetch PC, issues imem requests,
// and redirects on taken branches with a fixed-length pipeline flush.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, FETCH, REDIRECT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
      flush    <= 1'b0;
      misalign <= 1'b0;
      cnt      <= 4'd0;
    end else begin
      // misalign is a pulse; only the branch edge may raise it
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        FETCH: begin
          if (branch) begin
            pc       <= {branch_target[31:2], 2'b00};
            misalign <= |branch_target[1:0];
            flush    <= 1'b1;
            imem_req <= 1'b0;
            cnt      <= CNT_INIT;
            state    <= REDIRECT;
          end else if (!stall && imem_ready) begin
            pc <= pc_plus4;
          end
        end
        REDIRECT: begin
          // branch is ignored here: it belongs to a squashed instruction
          if (cnt == 4'd0) begin
            flush    <= 1'b0;
            imem_req <= 1'b1;
            state    <= FETCH;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          flush    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of fetch/flush bookkeeping.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FC     = 2;

  logic        clk = 1'b0;
  logic        rst_n, branch, stall, imem_ready;
  logic [31:0] branch_target;
  logic        imem_req, flush, misalign;
  logic [31:0] pc, pc_plus4;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [31:0] m_pc;
  logic        m_req, m_flush, m_mis;
  int          m_left;   // flush cycles still to run
  bit          m_up;     // idle cycle after reset already spent

  fetch_pc_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .branch_target(branch_target),
    .stall(stall), .imem_ready(imem_ready), .imem_req(imem_req), .pc(pc),
    .pc_plus4(pc_plus4), .flush(flush), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] obs();
    return {pc, pc_plus4, imem_req, flush, misalign};
  endfunction

  function automatic logic [66:0] expv();
    return {m_pc, m_pc + 32'd4, m_req, m_flush, m_mis};
  endfunction

  // Drive one cycle of inputs, advance model by one edge, settle for sampling.
  task automatic tick(input logic r, input logic b, input logic [31:0] t,
                      input logic s, input logic rdy);
    rst_n = r; branch = b; branch_target = t; stall = s; imem_ready = rdy;
    @(posedge clk);
    if (!r) begin
      m_pc = RST_PC; m_req = 0; m_flush = 0; m_mis = 0; m_left = 0; m_up = 0;
    end else if (!m_up) begin
      m_up = 1; m_req = 1; m_mis = 0;
    end else if (m_left > 0) begin
      m_mis = 0;
      m_left--;
      if (m_left == 0) begin m_flush = 0; m_req = 1; end
    end else begin
      m_mis = 0;
      if (b) begin
        m_pc = t & ~32'd3; m_mis = (t % 4) != 0;
        m_flush = 1; m_req = 0; m_left = FC;
      end else if (!s && rdy) begin
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(0, 1, 32'h55, 1, 1);
    tick(0, 0, 0, 0, 1);
    total++; if (obs() !== {RST_PC, RST_PC + 32'd4, 3'b000}) begin bad++;
      $display("FAIL reset_state got=%h exp=%h", obs(), {RST_PC, RST_PC + 32'd4, 3'b000}); end
    tick(1, 1, 32'h40, 0, 1);   // idle cycle: branch must be ignored
    total++; if (imem_req !== 1'b1 || pc !== RST_PC) begin bad++;
      $display("FAIL reset_idle req=%b pc=%h exp req=1 pc=%h", imem_req, pc, RST_PC); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 0, 1);
      total++; if (obs() !== expv()) begin bad++;
        $display("FAIL seq[%0d] got=%h exp=%h", i, obs(), expv()); end
    end
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL seq_pc got=%h exp=10", pc); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0);
      total++; if (obs() !== expv() || pc !== 32'h10 || !imem_req) begin bad++;
        $display("FAIL bp_hold[%0d] got=%h exp=%h", i, obs(), expv()); end
    end
    tick(1, 0, 0, 0, 1);
    total++; if (pc !== 32'h14) begin bad++; $display("FAIL bp_release got=%h exp=14", pc); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 1, 1);
      total++; if (pc !== 32'h14 || !imem_req) begin bad++;
        $display("FAIL stall_hold[%0d] pc=%h req=%b exp pc=14 req=1", i, pc, imem_req); end
    end
    tick(1, 1, 32'h100, 1, 1);
    total++; if (obs() !== expv() || pc !== 32'h100) begin bad++;
      $display("FAIL stall_branch got=%h exp=%h", obs(), expv()); end
    for (int i = 0; i < FC; i++) tick(1, 0, 0, 0, 0);
  endtask

  task automatic test_redirect();
    tick(1, 1, 32'h200, 0, 1);
    for (int i = 0; i < FC; i++) begin
      total++; if (flush !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h200) begin bad++;
        $display("FAIL redir_flush[%0d] flush=%b req=%b pc=%h exp 1 0 200", i, flush, imem_req, pc); end
      tick(1, 1, 32'h300, 0, 0);   // branch during flush is squashed
    end
    total++; if (flush !== 1'b0 || imem_req !== 1'b1 || pc !== 32'h200) begin bad++;
      $display("FAIL redir_end flush=%b req=%b pc=%h exp 0 1 200", flush, imem_req, pc); end
  endtask

  task automatic test_misalign();
    tick(1, 1, 32'h203, 0, 1);
    total++; if (misalign !== 1'b1 || pc !== 32'h200) begin bad++;
      $display("FAIL mis_first mis=%b pc=%h exp 1 200", misalign, pc); end
    tick(1, 0, 0, 0, 1);
    total++; if (misalign !== 1'b0 || obs() !== expv()) begin bad++;
      $display("FAIL mis_second got=%h exp=%h", obs(), expv()); end
    for (int i = 1; i < FC; i++) tick(1, 0, 0, 0, 1);
  endtask

  task automatic test_wrap();
    tick(1, 1, 32'hFFFF_FFFC, 0, 1);
    for (int i = 0; i < FC; i++) tick(1, 0, 0, 0, 1);
    total++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin bad++;
      $display("FAIL wrap_top pc=%h p4=%h exp FFFFFFFC 0", pc, pc_plus4); end
    tick(1, 0, 0, 0, 1);
    total++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin bad++;
      $display("FAIL wrap pc=%h p4=%h exp 0 4", pc, pc_plus4); end
    tick(1, 1, 32'h480, 0, 1);   // enter REDIRECT, then reset mid-flush
    tick(0, 0, 0, 0, 1);
    total++; if (pc !== RST_PC || flush !== 1'b0 || imem_req !== 1'b0) begin bad++;
      $display("FAIL reset_redirect pc=%h flush=%b req=%b exp %h 0 0", pc, flush, imem_req, RST_PC); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0), $urandom(),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
      total++; if (obs() !== expv()) begin bad++;
        $display("FAIL rand[%0d] got=%h exp=%h", i, obs(), expv()); end
    end
  endtask

  initial begin
    m_pc = RST_PC; m_req = 0; m_flush = 0; m_mis = 0; m_left = 0; m_up = 0;
    rst_n = 0; branch = 0; branch_target = 0; stall = 0; imem_ready = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_stall();
    test_redirect();
    test_misalign();
    test_wrap();
    tick(1, 0, 0, 0, 0);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
